// File: rtl/wb_memory_responder.sv
// Write-back memory responder: collects one cache line from the write-back
// buffer, writes it word by word to main memory, then acknowledges the line.
module wb_memory_responder #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_ready_to_send,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic [ADDRESS_WIDTH-1:0] wb_address,
  output logic                     wb_accept,
  output logic                     wb_ack,
  output logic                     wb_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ready
);

  localparam int unsigned WORDS = BLOCK_SIZE * 8 / DATA_WIDTH;
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK  = ADDRESS_WIDTH'(BLOCK_SIZE - 1);
  // Counter value one short of all-ones: the stalled edge seen at this value
  // is the one on which the counter reaches its limit.
  localparam logic [COUNTER_WIDTH-1:0] STALL_LIM = {{(COUNTER_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [COUNTER_WIDTH-1:0]   stall_q;
  logic [ADDRESS_WIDTH-1:0]   base_q;
  logic                       accept_q;
  logic                       ack_q;
  logic                       err_q;
  logic                       we_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [DATA_WIDTH-1:0]      words_q [WORDS];

  logic                       capture_c;
  logic [IDX_W-1:0]           idx_inc_c;
  logic [IDX_W-1:0]           wr_idx_c;
  logic [ADDRESS_WIDTH-1:0]   base_d;

  // Byte address of word idx within the line starting at base (wraps).
  function automatic logic [ADDRESS_WIDTH-1:0] word_addr(
    input logic [ADDRESS_WIDTH-1:0] base,
    input logic [IDX_W-1:0]         idx
  );
    return base + ADDRESS_WIDTH'(idx) * ADDRESS_WIDTH'(BYTES);
  endfunction

  assign capture_c = accept_q & wb_ready_to_send;
  assign idx_inc_c = idx_q + IDX_W'(1);
  assign wr_idx_c  = (state_q == S_IDLE) ? '0 : idx_q;
  assign base_d    = wb_address & ~OFF_MASK;

  assign wb_accept = accept_q;
  assign wb_ack    = ack_q;
  assign wb_err    = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Line buffer: store each captured word at its slot (no reset needed).
  always_ff @(posedge clk) begin
    if (capture_c) begin
      words_q[wr_idx_c] <= wb_data;
    end
  end

  // Control FSM with registered handshake and memory-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      stall_q  <= '0;
      base_q   <= '0;
      accept_q <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (capture_c) begin
            base_q  <= base_d;
            stall_q <= '0;
            if (LAST_IDX == '0) begin
              state_q  <= S_WRITE;
              idx_q    <= '0;
              accept_q <= 1'b0;
              we_q     <= 1'b1;
              addr_q   <= base_d;
              wdata_q  <= wb_data;
            end else begin
              state_q <= S_COLLECT;
              idx_q   <= IDX_W'(1);
            end
          end
        end
        S_COLLECT: begin
          if (capture_c) begin
            stall_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q  <= S_WRITE;
              idx_q    <= '0;
              accept_q <= 1'b0;
              we_q     <= 1'b1;
              addr_q   <= base_q;
              wdata_q  <= words_q[0];
            end else begin
              idx_q <= idx_inc_c;
            end
          end else if (stall_q == STALL_LIM) begin
            // Writer went quiet for too long: drop the partial line.
            state_q <= S_IDLE;
            idx_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b1;
          end else begin
            stall_q <= stall_q + COUNTER_WIDTH'(1);
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_ACK;
              idx_q   <= '0;
              we_q    <= 1'b0;
              ack_q   <= 1'b1;
            end else begin
              idx_q   <= idx_inc_c;
              addr_q  <= word_addr(base_q, idx_inc_c);
              wdata_q <= words_q[idx_inc_c];
            end
          end
        end
        S_ACK: begin
          state_q  <= S_IDLE;
          accept_q <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          accept_q <= 1'b1;
          we_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_memory_responder.sv
// Directed bench for wb_memory_responder at default parameters.
module tb_wb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_ready_to_send;
  logic [31:0] wb_data;
  logic [31:0] wb_address;
  logic        wb_accept;
  logic        wb_ack;
  logic        wb_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int we_cnt = 0;
  int viol = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  wb_memory_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_ready_to_send (wb_ready_to_send),
    .wb_data          (wb_data),
    .wb_address       (wb_address),
    .wb_accept        (wb_accept),
    .wb_ack           (wb_ack),
    .wb_err           (wb_err),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ready        (mem_ready)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: completed writes, pulses, and accept-while-busy.
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
    end
    if (wb_ack) begin
      ack_cnt <= ack_cnt + 1;
      ack_cyc <= cyc;
    end
    if (wb_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
    if (wb_accept && (mem_we || wb_ack)) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_words(input logic [31:0] addr, input logic [31:0] d0, input int n,
                            input int gap_at, input int gap_len,
                            output int c0, output int c_last);
    c0 = 0;
    c_last = 0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        wb_ready_to_send = 1'b0;
        repeat (gap_len) tick();
      end
      wb_ready_to_send = 1'b1;
      wb_address = addr;
      wb_data = d0 + 32'(i);
      tick();
      if (i == 0) c0 = cyc;
      c_last = cyc;
    end
    wb_ready_to_send = 1'b0;
  endtask

  task automatic wait_ack(input logic [31:0] stall_addr, input int stall_len, input bit poke);
    int start;
    bit stalled;
    start = ack_cnt;
    stalled = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (ack_cnt != start) break;
      if (poke) begin
        wb_ready_to_send = mem_we;
        wb_data = 32'hDEAD_BEEF;
      end
      if (stall_len > 0 && !stalled && mem_we && mem_addr == stall_addr) begin
        mem_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          chk("stall_we", 64'(mem_we), 64'd1);
          chk("stall_addr", 64'(mem_addr), 64'(stall_addr));
        end
        mem_ready = 1'b1;
        stalled = 1'b1;
      end
      tick();
    end
    wb_ready_to_send = 1'b0;
    if (ack_cnt == start) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_line(input string tag, input logic [31:0] base, input logic [31:0] d0);
    chk({tag, "_nwr"}, 64'(q_addr.size()), 64'd8);
    if (q_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'(base + 32'(4 * i)));
        chk($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(d0 + 32'(i)));
      end
    end
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    int c0, cl, a0, e0, w0;
    rst_n = 1'b0;
    wb_ready_to_send = 1'b0;
    wb_data = '0;
    wb_address = '0;
    mem_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_accept", 64'(wb_accept), 64'd1);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_ack", 64'(wb_ack), 64'd0);
    chk("rst_err", 64'(wb_err), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);

    // Back-to-back line, writer pokes during WRITE (must be ignored).
    a0 = ack_cnt;
    send_words(32'h1000_0014, 32'hA0, 8, -1, 0, c0, cl);
    wait_ack(32'h0, 0, 1'b1);
    repeat (3) tick();
    check_line("l1", 32'h1000_0000, 32'hA0);
    chk("l1_lat", 64'(ack_cyc - c0), 64'd15);
    chk("l1_acks", 64'(ack_cnt - a0), 64'd1);
    chk("l1_busy_accept", 64'(viol), 64'd0);
    chk("l1_accept_after", 64'(wb_accept), 64'd1);

    // Writer gap of 3 cycles before word 3.
    send_words(32'h1000_0014, 32'hA0, 8, 3, 3, c0, cl);
    wait_ack(32'h0, 0, 1'b0);
    repeat (2) tick();
    check_line("l2", 32'h1000_0000, 32'hA0);
    chk("l2_lat", 64'(ack_cyc - c0), 64'd18);

    // Memory holds off 5 cycles on word 4.
    send_words(32'h2000_0008, 32'hB0, 8, -1, 0, c0, cl);
    wait_ack(32'h2000_0010, 5, 1'b0);
    repeat (2) tick();
    check_line("l3", 32'h2000_0000, 32'hB0);
    chk("l3_lat", 64'(ack_cyc - c0), 64'd20);

    // Writer stalls after word 1 until the timeout fires.
    a0 = ack_cnt;
    e0 = err_cnt;
    w0 = we_cnt;
    send_words(32'h3000_0000, 32'hC0, 2, -1, 0, c0, cl);
    for (int n = 0; n < 400 && err_cnt == e0; n++) tick();
    repeat (3) tick();
    chk("to_errs", 64'(err_cnt - e0), 64'd1);
    chk("to_lat", 64'(err_cyc - cl), 64'd255);
    chk("to_acks", 64'(ack_cnt - a0), 64'd0);
    chk("to_we", 64'(we_cnt - w0), 64'd0);
    chk("to_accept", 64'(wb_accept), 64'd1);
    q_addr.delete();
    q_data.delete();

    // Reset while word 3 is being written.
    a0 = ack_cnt;
    e0 = err_cnt;
    send_words(32'h4000_0000, 32'hD0, 8, -1, 0, c0, cl);
    for (int n = 0; n < 50 && !(mem_we && mem_addr == 32'h4000_000C); n++) tick();
    chk("rw_reached", 64'(mem_addr), 64'h4000_000C);
    rst_n = 1'b0;
    tick();
    chk("rw_we_off", 64'(mem_we), 64'd0);
    tick();
    rst_n = 1'b1;
    w0 = we_cnt;
    repeat (4) tick();
    chk("rw_we_none", 64'(we_cnt - w0), 64'd0);
    chk("rw_acks", 64'(ack_cnt - a0), 64'd0);
    chk("rw_errs", 64'(err_cnt - e0), 64'd0);
    chk("rw_accept", 64'(wb_accept), 64'd1);
    q_addr.delete();
    q_data.delete();
    send_words(32'h4000_0000, 32'hE0, 8, -1, 0, c0, cl);
    wait_ack(32'h0, 0, 1'b0);
    repeat (2) tick();
    check_line("l5", 32'h4000_0000, 32'hE0);
    chk("l5_lat", 64'(ack_cyc - c0), 64'd15);

    // Line at the top of the address space.
    send_words(32'hFFFF_FFF4, 32'hF0, 8, -1, 0, c0, cl);
    wait_ack(32'h0, 0, 1'b0);
    repeat (2) tick();
    check_line("l6", 32'hFFFF_FFE0, 32'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_memory_responder.md
WB_MEMORY_RESPONDER -- requirements
Module: wb_memory_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of one write-back word.
REQ-002 Parameter BLOCK_SIZE, default 32, SHALL set the cache line size in bytes; WORDS = BLOCK_SIZE*8/DATA_WIDTH (8 at defaults).
REQ-003 Parameter ADDRESS_WIDTH, default 32, SHALL set the byte address width.
REQ-004 Parameter COUNTER_WIDTH, default 8, SHALL set the width of the collect-stall timeout counter.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-007 wb_ready_to_send  input  1  SHALL mean the write-back buffer presents a valid word this cycle.
REQ-008 wb_data  input  DATA_WIDTH  SHALL carry the current write-back word.
REQ-009 wb_address  input  ADDRESS_WIDTH  SHALL carry the block address of the line being written back.
REQ-010 wb_accept  output  1  SHALL mean the responder can capture a word this cycle.
REQ-011 wb_ack  output  1  SHALL be a one-cycle pulse confirming the whole line reached memory.
REQ-012 wb_err  output  1  SHALL be a one-cycle pulse signalling a collect timeout abort.
REQ-013 mem_we  output  1  SHALL request a word write to main memory.
REQ-014 mem_addr  output  ADDRESS_WIDTH  SHALL carry the word byte address.
REQ-015 mem_wdata  output  DATA_WIDTH  SHALL carry the word data.
REQ-016 mem_ready  input  1  SHALL mean memory accepts the write this cycle.

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, WRITE, ACK.
REQ-018 A word capture SHALL occur on an edge where wb_accept=1 and wb_ready_to_send=1.
REQ-019 wb_accept SHALL be 1 in IDLE and COLLECT, 0 in WRITE and ACK; wb_ready_to_send in WRITE/ACK SHALL be ignored.
REQ-020 IDLE capture: latch base = wb_address with low log2(BLOCK_SIZE) bits zeroed, store word 0, word index=1, go COLLECT.
REQ-021 COLLECT capture: store wb_data at word index, increment index; capture of word WORDS-1 SHALL move to WRITE with index=0.
REQ-022 COLLECT with wb_ready_to_send=0 SHALL hold index and stored words (stall).
REQ-023 Stall counter SHALL clear on every capture, increment each stalled COLLECT cycle; reaching 2^COUNTER_WIDTH-1 SHALL pulse wb_err, discard data, return to IDLE, no wb_ack.
REQ-024 In WRITE, mem_we=1, mem_addr = base + index*(DATA_WIDTH/8), mem_wdata = stored word[index]; mem_we=0 elsewhere.
REQ-025 A write SHALL complete on an edge with mem_we=1 and mem_ready=1; index increments; completion of word WORDS-1 moves to ACK.
REQ-026 mem_ready=0 SHALL hold mem_addr, mem_wdata, index stable, with no timeout in WRITE.
REQ-027 ACK SHALL assert wb_ack for exactly one cycle, then return to IDLE; a new capture is possible the following cycle.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-029 Latency: with continuous wb_ready_to_send and mem_ready=1, wb_ack SHALL be high in the cycle following the 15th edge after word 0 capture (WORDS=8).

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE, index=0, stall counter=0, wb_ack=0, wb_err=0, mem_we=0, mem_addr=0, mem_wdata=0; wb_accept=1 after release.
REQ-031 Reset mid-COLLECT or mid-WRITE SHALL abandon the line with no wb_ack, no wb_err, no further mem_we.

Verification
REQ-032 Line wb_address=0x1000_0014, words 0xA0..0xA7 back-to-back, mem_ready=1 -> 8 writes at 0x1000_0000..0x1000_001C with data 0xA0..0xA7, one wb_ack pulse, wb_accept=0 during WRITE/ACK.
REQ-033 wb_ready_to_send dropped 3 cycles after word 2 -> no capture during gap, index held at 3, final memory contents identical to gapless run.
REQ-034 mem_ready=0 for 5 cycles at word 4 -> mem_we stays 1 with mem_addr=base+0x10 stable; wb_ack delayed exactly 5 cycles.
REQ-035 Stall 255 cycles after word 1 (COUNTER_WIDTH=8) -> wb_err pulse, no mem_we, no wb_ack, IDLE with wb_accept=1.
REQ-036 rst_n=0 during WRITE word 3 -> mem_we=0 next cycle, no wb_ack; next line completes normally.
REQ-037 Base address 0xFFFF_FFE0 -> last mem_addr 0xFFFF_FFFC, no overflow corruption.
